// File: rtl/lzc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lzc_pipe
// Brief    : Two-stage elastic leading/trailing-zero counter. It produces a
//            segmented count, a one-hot position and an all-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module lzc_pipe #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8,
    parameter int TAG_W     = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [WIDTH-1:0]            in_data_i,
    input  logic                        in_dir_i,
    input  logic [TAG_W-1:0]            in_tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [$clog2(WIDTH+1)-1:0]  out_cnt_o,
    output logic [WIDTH-1:0]            out_onehot_o,
    output logic                        out_zero_o,
    output logic [TAG_W-1:0]            out_tag_o
);

    localparam int c_NSEG = WIDTH / SEG_WIDTH;
    localparam int c_CW   = $clog2(WIDTH + 1);
    localparam int c_LCW  = $clog2(SEG_WIDTH + 1);

    generate
        if ((WIDTH < 2) || (SEG_WIDTH < 2) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_param_err
            $error("lzc_pipe: WIDTH and SEG_WIDTH must be >= 2 and WIDTH a multiple of SEG_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_adv;
    logic w_s2_adv;

    assign w_s2_adv   = ~r_s2_valid | out_ready_i;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign in_ready_o = w_s1_adv & ~rst_i;

    // ------------------------------------------------------------------
    // Stage 1 combinational: per-segment local scan in both directions
    // ------------------------------------------------------------------
    logic [c_NSEG-1:0]                 w_seg_zero;
    logic [c_NSEG-1:0][c_LCW-1:0]      w_seg_cnt;
    logic [c_NSEG-1:0][SEG_WIDTH-1:0]  w_seg_oh;

    generate
        for (genvar j = 0; j < c_NSEG; j++) begin : g_seg
            logic [SEG_WIDTH-1:0] w_bits;
            logic                 w_lfound;
            logic                 w_tfound;
            logic [c_LCW-1:0]     w_lcnt;
            logic [c_LCW-1:0]     w_tcnt;
            logic [SEG_WIDTH-1:0] w_loh;
            logic [SEG_WIDTH-1:0] w_toh;

            assign w_bits = in_data_i[j*SEG_WIDTH +: SEG_WIDTH];

            always_comb begin
                w_lfound = 1'b0;
                w_tfound = 1'b0;
                w_lcnt   = c_LCW'(SEG_WIDTH);
                w_tcnt   = c_LCW'(SEG_WIDTH);
                w_loh    = '0;
                w_toh    = '0;
                for (int i = 0; i < SEG_WIDTH; i++) begin
                    if (!w_lfound && w_bits[SEG_WIDTH-1-i]) begin
                        w_lfound               = 1'b1;
                        w_lcnt                 = c_LCW'(i);
                        w_loh[SEG_WIDTH-1-i]   = 1'b1;
                    end
                    if (!w_tfound && w_bits[i]) begin
                        w_tfound = 1'b1;
                        w_tcnt   = c_LCW'(i);
                        w_toh[i] = 1'b1;
                    end
                end
            end

            assign w_seg_zero[j] = ~|w_bits;
            assign w_seg_cnt[j]  = in_dir_i ? w_tcnt : w_lcnt;
            assign w_seg_oh[j]   = in_dir_i ? w_toh  : w_loh;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [c_NSEG-1:0]                 r_s1_zero;
    logic [c_NSEG-1:0][c_LCW-1:0]      r_s1_cnt;
    logic [c_NSEG-1:0][SEG_WIDTH-1:0]  r_s1_oh;
    logic                              r_s1_dir;
    logic [TAG_W-1:0]                  r_s1_tag;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= '0;
            r_s1_cnt   <= '0;
            r_s1_oh    <= '0;
            r_s1_dir   <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_zero <= w_seg_zero;
                r_s1_cnt  <= w_seg_cnt;
                r_s1_oh   <= w_seg_oh;
                r_s1_dir  <= in_dir_i;
                r_s1_tag  <= in_tag_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: pick the first non-zero segment
    // ------------------------------------------------------------------
    logic             w_lead_found;
    logic             w_trail_found;
    logic [c_CW-1:0]  w_lead_cnt;
    logic [c_CW-1:0]  w_trail_cnt;
    logic [WIDTH-1:0] w_lead_oh;
    logic [WIDTH-1:0] w_trail_oh;
    logic             w_all_zero;

    always_comb begin
        w_lead_found  = 1'b0;
        w_trail_found = 1'b0;
        w_lead_cnt    = c_CW'(WIDTH);
        w_trail_cnt   = c_CW'(WIDTH);
        w_lead_oh     = '0;
        w_trail_oh    = '0;
        // p counts the all-zero segments already skipped in scan order
        for (int p = 0; p < c_NSEG; p++) begin
            if (!w_lead_found && !r_s1_zero[c_NSEG-1-p]) begin
                w_lead_found = 1'b1;
                w_lead_cnt   = c_CW'(p * SEG_WIDTH) + c_CW'(r_s1_cnt[c_NSEG-1-p]);
                w_lead_oh[(c_NSEG-1-p)*SEG_WIDTH +: SEG_WIDTH] = r_s1_oh[c_NSEG-1-p];
            end
            if (!w_trail_found && !r_s1_zero[p]) begin
                w_trail_found = 1'b1;
                w_trail_cnt   = c_CW'(p * SEG_WIDTH) + c_CW'(r_s1_cnt[p]);
                w_trail_oh[p*SEG_WIDTH +: SEG_WIDTH] = r_s1_oh[p];
            end
        end
    end

    assign w_all_zero = &r_s1_zero;

    // ------------------------------------------------------------------
    // Stage 2 registers drive the outputs directly
    // ------------------------------------------------------------------
    logic [c_CW-1:0]  r_s2_cnt;
    logic [WIDTH-1:0] r_s2_oh;
    logic             r_s2_zero;
    logic [TAG_W-1:0] r_s2_tag;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_cnt   <= '0;
            r_s2_oh    <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_cnt  <= r_s1_dir ? w_trail_cnt : w_lead_cnt;
                r_s2_oh   <= r_s1_dir ? w_trail_oh  : w_lead_oh;
                r_s2_zero <= w_all_zero;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    assign out_valid_o  = r_s2_valid;
    assign out_cnt_o    = r_s2_cnt;
    assign out_onehot_o = r_s2_oh;
    assign out_zero_o   = r_s2_zero;
    assign out_tag_o    = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_lzc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzc_pipe
// Brief    : Self-checking bench for lzc_pipe (32/8 and 8/4 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lzc_pipe;

    typedef struct {
        int          cnt;
        logic [31:0] oh;
        logic        zero;
        logic [7:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data  = '0;
    logic        in_dir   = 1'b0;
    logic [7:0]  in_tag   = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_cnt;
    logic [31:0] out_oh;
    logic        out_zero;
    logic [7:0]  out_tag;

    // 8-bit instance
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  in_data8  = '0;
    logic        in_dir8   = 1'b0;
    logic [0:0]  in_tag8   = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [3:0]  out_cnt8;
    logic [7:0]  out_oh8;
    logic        out_zero8;
    logic [0:0]  out_tag8;

    lzc_pipe #(.WIDTH(32), .SEG_WIDTH(8), .TAG_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_dir_i(in_dir), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_cnt_o(out_cnt),
        .out_onehot_o(out_oh), .out_zero_o(out_zero), .out_tag_o(out_tag)
    );

    lzc_pipe #(.WIDTH(8), .SEG_WIDTH(4), .TAG_W(1)) u_dut8 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8), .in_data_i(in_data8),
        .in_dir_i(in_dir8), .in_tag_i(in_tag8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8), .out_cnt_o(out_cnt8),
        .out_onehot_o(out_oh8), .out_zero_o(out_zero8), .out_tag_o(out_tag8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_out8  = 0;
    logic ready_rand = 1'b0;

    exp_t q32[$];
    exp_t q8[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: isolate the lowest set bit with v & -v, or find the highest via log2
    function automatic exp_t model(input logic [31:0] d, input logic dir, input int w,
                                   input logic [7:0] tag);
        exp_t            e;
        longint unsigned v;
        longint unsigned low;
        int              msb;
        v     = {32'b0, d};
        e.tag = tag;
        if (v == 0) begin
            e.cnt  = w;
            e.oh   = '0;
            e.zero = 1'b1;
        end else if (dir) begin
            low    = v & (~v + 64'd1);
            e.cnt  = $clog2(low);
            e.oh   = low[31:0];
            e.zero = 1'b0;
        end else begin
            msb    = $clog2(v + 64'd1) - 1;
            e.cnt  = w - 1 - msb;
            e.oh   = 32'(64'd1 << msb);
            e.zero = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (ready_rand) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard for the 32-bit instance
    exp_t        e32;
    logic        held = 1'b0;
    logic [5:0]  h_cnt;
    logic [31:0] h_oh;
    logic [7:0]  h_tag;

    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
            held = 1'b0;
            chk("in_ready_during_rst", in_ready, 1'b0);
        end else begin
            chk("in_ready", in_ready, !(q32.size() == 2 && !out_ready));
            if (held) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_cnt", out_cnt, h_cnt);
                chk("hold_oh", out_oh, h_oh);
                chk("hold_tag", out_tag, h_tag);
            end
            if (out_valid && q32.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else if (out_valid && out_ready) begin
                e32 = q32.pop_front();
                chk("cnt", out_cnt, 64'(e32.cnt));
                chk("onehot", out_oh, e32.oh);
                chk("zero", out_zero, e32.zero);
                chk("tag", out_tag, e32.tag);
                n_out++;
            end
            held  = out_valid && !out_ready;
            h_cnt = out_cnt;
            h_oh  = out_oh;
            h_tag = out_tag;
            if (in_valid && in_ready)
                q32.push_back(model(in_data, in_dir, 32, in_tag));
        end
    end

    // Scoreboard for the 8-bit instance (always ready downstream)
    exp_t e8;
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
        end else begin
            chk("in_ready8", in_ready8, 1'b1);
            if (out_valid8 && q8.size() == 0) begin
                chk("spurious_out8", out_valid8, 1'b0);
            end else if (out_valid8) begin
                e8 = q8.pop_front();
                chk("cnt8", out_cnt8, 64'(e8.cnt));
                chk("onehot8", out_oh8, e8.oh);
                chk("zero8", out_zero8, e8.zero);
                chk("tag8", out_tag8, e8.tag);
                n_out8++;
            end
            if (in_valid8 && in_ready8)
                q8.push_back(model({24'b0, in_data8}, in_dir8, 8, {7'b0, in_tag8}));
        end
    end

    task automatic send(input logic [31:0] d, input logic dir, input logic [7:0] tag);
        int   guard;
        logic acc;
        guard    = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_tag   = tag;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("send_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe with out_ready high
    task automatic expect_one(input logic [31:0] d, input logic dir, input int c,
                              input logic [31:0] oh, input logic z);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_tag   = 8'hA5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1'b1);
        chk("dir_cnt", out_cnt, 64'(c));
        chk("dir_onehot", out_oh, oh);
        chk("dir_zero", out_zero, z);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          g;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_cnt", out_cnt, 6'd0);
        chk("rst_oh", out_oh, 32'd0);
        chk("rst_zero", out_zero, 1'b0);
        chk("rst_tag", out_tag, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        expect_one(32'h0000_0500, 1'b0, 21, 32'h0000_0400, 1'b0);
        expect_one(32'h0028_0000, 1'b1, 19, 32'h0008_0000, 1'b0);
        expect_one(32'h8000_0000, 1'b0, 0,  32'h8000_0000, 1'b0);
        expect_one(32'h0000_0001, 1'b1, 0,  32'h0000_0001, 1'b0);
        expect_one(32'h0000_0000, 1'b0, 32, 32'h0000_0000, 1'b1);
        expect_one(32'h0000_0000, 1'b1, 32, 32'h0000_0000, 1'b1);

        // Random stream under random backpressure
        n0         = n_out;
        ready_rand = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            d = $urandom;
            d = d >> $urandom_range(0, 31);
            d = d << $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) d = '0;
            send(d, 1'(i % 2), 8'(i));
        end
        ready_rand = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        g = 0;
        while (q32.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_empty", 64'(q32.size()), 64'd0);
        chk("stream_count", 64'(n_out - n0), 64'd100);

        // Reset with two beats in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h00F0_0000, 1'b0, 8'h11);
        send(32'h0000_0F00, 1'b1, 8'h22);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_drop_valid", out_valid, 1'b0);
        n0 = n_out;
        @(posedge clk);
        #1;
        expect_one(32'h0000_0001, 1'b0, 31, 32'h0000_0001, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_only_output", 64'(n_out - n0), 64'd1);

        // Exhaustive 8-bit, back-to-back
        n0        = n_out8;
        in_valid8 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            in_data8 = 8'(i);
            in_dir8  = 1'(i >> 8);
            in_tag8  = 1'(i);
            @(posedge clk);
            #1;
        end
        in_valid8 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("exh8_rate", 64'(n_out8 - n0), 64'd512);
        repeat (3) @(posedge clk);
        #1;
        chk("exh8_total", 64'(n_out8 - n0), 64'd512);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lzc_pipe.md
# lzc_pipe

Pipelined, elastic leading/trailing-zero counter for one operand per cycle. It is the sequential successor to the combinational leading-zero detector, and is generalised in four ways:
- runtime direction (leading or trailing),
- segmented two-level counting for wide operands,
- binary count and all-zero flag alongside the one-hot position,
- valid/ready flow control with a sideband tag.

It sits in normalisation paths of FP and fixed-point datapaths, between an operand producer and a shifter.

## Interface
Parameters:
- WIDTH, 32: operand width. Must be ≥ 2.
- SEG_WIDTH, 8: width of a first-level segment. Must be ≥ 2. WIDTH % SEG_WIDTH must be 0; elaboration fails otherwise.
- TAG_W, 1: width of the sideband tag carried alongside the operand.

Derived values:
- NSEG = WIDTH/SEG_WIDTH.
- CW = $clog2(WIDTH+1).

Ports:
- clk_i, in, 1: clock. One clock; all state is updated on the rising edge.
- rst_i, in, 1: reset. Synchronous, active-high.
- in_valid_i, in, 1: input beat valid.
- in_ready_o, out, 1: input beat accepted when in_valid_i & in_ready_o.
- in_data_i, in, WIDTH: operand.
- in_dir_i, in, 1: 0 = count leading zeros (from MSB); 1 = count trailing zeros (from LSB).
- in_tag_i, in, TAG_W: sideband, passed through unchanged.
- out_valid_o, out, 1: result valid.
- out_ready_i, in, 1: result consumed when out_valid_o & out_ready_i.
- out_cnt_o, out, CW: number of zeros before the first '1' in the selected direction.
- out_onehot_o, out, WIDTH: only the bit at the first '1' is set.
- out_zero_o, out, 1: operand was all zeros.
- out_tag_o, out, TAG_W: tag of this result.

## Operation
- Stage 1 (register S1), on input handshake:
  - Split the operand into NSEG segments; segment j = bits [j*SEG_WIDTH +: SEG_WIDTH].
  - Per segment, store:
    - seg_zero[j];
    - the local count in the selected direction, $clog2(SEG_WIDTH+1) bits;
    - the local one-hot position, SEG_WIDTH bits.
  - Also store the direction and the tag.
- Stage 2 (register S2), on S1→S2 transfer:
  - Select the first non-zero segment k in the selected direction: highest index for dir=0, lowest index for dir=1.
  - cnt = (number of all-zero segments passed before k) * SEG_WIDTH + local count of k.
  - onehot = local one-hot of k placed at segment k; all other bits are 0.
  - zero = AND of all seg_zero.
- All-zero operand: cnt = WIDTH, onehot = 0, zero = 1, in either direction.
- Single-bit results:
  - dir=0: the MSB set gives cnt=0, onehot bit WIDTH-1.
  - dir=1: the LSB set gives cnt=0, onehot bit 0.
- Results must match the behavioural model for every input: leading/trailing scan, all-zero → WIDTH.
- Outputs are driven directly from S2 registers; there is no combinational path from in_data_i to out_*.
- Reset:
  - Values after reset: S1/S2 valid = 0; all S2 data registers = 0. Hence out_valid_o=0, out_cnt_o=0, out_onehot_o=0, out_zero_o=0, out_tag_o=0.
  - in_ready_o = 0 while rst_i is high.
  - Reset mid-operation drops all in-flight beats. No result for them is ever presented.

## Timing
- Latency: 2 cycles. A beat accepted at edge t appears on out_* after edge t+1 (valid in cycle t+1→t+2), provided there is no stall.
- Throughput: 1 beat/cycle with out_ready_i held high. There are no bubbles.
- Stage advance rules:
  - s2_adv = ~s2_valid | out_ready_i.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready_o = s1_adv & ~rst_i.
  - The combinational path out_ready_i → in_ready_o is permitted; no other path is.
- Backpressure:
  - While out_valid_o & ~out_ready_i, out_* stay stable.
  - With both stages full, in_ready_o = 0.
  - Exactly two beats are buffered; no beat is lost or duplicated.
- Simultaneous events: output consumption and input acceptance in the same cycle are both honoured; the pipeline shifts.
- Direction and tag are captured per beat. Mixed directions in flight do not interact.
- in_valid_i with in_ready_o = 0: the beat is not taken. The producer must hold it.
- Results stay in order, with no reordering.

## Test plan
- WIDTH=32, SEG_WIDTH=8, dir=0, data=0x0000_0500, no stall → cnt=21, onehot=0x0000_0400, zero=0, valid 2 cycles after accept.
- dir=1, data=0x0028_0000 (lowest set bit is bit 19) → cnt=19, onehot=0x0008_0000. Then data=0x8000_0000, dir=0 → cnt=0, onehot=0x8000_0000.
- data=0 with dir=0 and with dir=1 → cnt=32, onehot=0, zero=1 for both.
- Stream 100 random beats with random out_ready_i (50%) and alternating dir, tag = sequence number → every result matches the behavioural model, tags arrive in order, and none are missing or duplicated. in_ready_o is low only when both stages are full.
- Assert rst_i for 1 cycle with 2 beats in flight → out_valid_o=0 the following cycle and in_ready_o=0 during reset. The next accepted beat (data=0x0000_0001, dir=0 → cnt=31) is the only output.
- WIDTH=8, SEG_WIDTH=4, exhaustive 256 operands × 2 directions, back-to-back → all match the model at 1 result/cycle.
